// File: rtl/execute_mc_if.sv
// Execute-stage bundle: decode-side offer, memory-side result, status.
// Also carries the shared IR-source and canned-instruction encodings.
`ifndef EXECUTE_MC_DEFS
`define EXECUTE_MC_DEFS
`define IR_SRC_DATA     2'd0
`define IR_SRC_NOP      2'd1
`define IR_SRC_EXCEPT   2'd2
`define INST_NOP        32'h0000_0000
`define INST_BNE_EXCEPT 32'h4800_0001
`endif

// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and offered data stays stable while held.
interface execute_mc_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      ir_src;
   logic            flush;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_a;
   logic [XLEN-1:0] in_b;
   logic [XLEN-1:0] in_st;
   logic [31:0]     in_ir;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_y;
   logic [XLEN-1:0] out_st;
   logic [31:0]     out_ir;
   logic            busy;
   logic [1:0]      dbg_state;

   modport master (
      output in_valid, ir_src, flush, in_pc, in_a, in_b, in_st, in_ir, out_ready,
      input  in_ready, out_valid, out_pc, out_y, out_st, out_ir, busy, dbg_state
   );
   modport slave (
      input  in_valid, ir_src, flush, in_pc, in_a, in_b, in_st, in_ir, out_ready,
      output in_ready, out_valid, out_pc, out_y, out_st, out_ir, busy, dbg_state
   );
endinterface

// File: rtl/execute_mc.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier,
// with a one-entry output hold register feeding the memory stage.
`ifndef EXECUTE_MC_DEFS
`define EXECUTE_MC_DEFS
`define IR_SRC_DATA     2'd0
`define IR_SRC_NOP      2'd1
`define IR_SRC_EXCEPT   2'd2
`define INST_NOP        32'h0000_0000
`define INST_BNE_EXCEPT 32'h4800_0001
`endif

module execute_mc #(
   parameter int XLEN   = 32,
   parameter bit MUL_EN = 1'b1
) (
   input logic         clk,
   input logic         rst_n,
   execute_mc_if.slave bus
);
   localparam int SW = $clog2(XLEN);
   localparam int CW = $clog2(XLEN + 1);

   localparam logic [5:0] OP_ADD   = 6'h01;
   localparam logic [5:0] OP_SUB   = 6'h02;
   localparam logic [5:0] OP_AND   = 6'h03;
   localparam logic [5:0] OP_OR    = 6'h04;
   localparam logic [5:0] OP_XOR   = 6'h05;
   localparam logic [5:0] OP_XNOR  = 6'h06;
   localparam logic [5:0] OP_SHL   = 6'h07;
   localparam logic [5:0] OP_SHR   = 6'h08;
   localparam logic [5:0] OP_SRA   = 6'h09;
   localparam logic [5:0] OP_CMPEQ = 6'h0A;
   localparam logic [5:0] OP_CMPLT = 6'h0B;
   localparam logic [5:0] OP_CMPLE = 6'h0C;
   localparam logic [5:0] OP_LD    = 6'h0D;
   localparam logic [5:0] OP_ST    = 6'h0E;
   localparam logic [5:0] OP_LDR   = 6'h0F;
   localparam logic [5:0] OP_MUL   = 6'h10;
   localparam logic [5:0] OP_MULC  = 6'h11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_HOLD = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, st_q, st_d, y_q, y_d;
   logic [XLEN-1:0] mcand_q, mcand_d, mplier_q, mplier_d;
   logic [31:0]     ir_q, ir_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [31:0]     sel_ir;
   logic [5:0]      op;
   logic [SW-1:0]   shamt;
   logic            is_mul;
   logic            rdy;
   logic            accept;
   logic [XLEN-1:0] alu_y;

   always_comb begin
      case (bus.ir_src)
         `IR_SRC_DATA:   sel_ir = bus.in_ir;
         `IR_SRC_EXCEPT: sel_ir = `INST_BNE_EXCEPT;
         default:        sel_ir = `INST_NOP;
      endcase
      op     = sel_ir[31:26];
      shamt  = bus.in_b[SW-1:0];
      is_mul = (MUL_EN != 1'b0) && (op == OP_MUL || op == OP_MULC);
      alu_y  = '0;
      case (op)
         OP_ADD, OP_LD, OP_ST: alu_y = bus.in_a + bus.in_b;
         OP_SUB:   alu_y = bus.in_a - bus.in_b;
         OP_AND:   alu_y = bus.in_a & bus.in_b;
         OP_OR:    alu_y = bus.in_a | bus.in_b;
         OP_XOR:   alu_y = bus.in_a ^ bus.in_b;
         OP_XNOR:  alu_y = ~(bus.in_a ^ bus.in_b);
         OP_SHL:   alu_y = bus.in_a << shamt;
         OP_SHR:   alu_y = bus.in_a >> shamt;
         OP_SRA:   alu_y = $signed(bus.in_a) >>> shamt;
         OP_CMPEQ: alu_y = {{(XLEN-1){1'b0}}, bus.in_a == bus.in_b};
         OP_CMPLT: alu_y = {{(XLEN-1){1'b0}}, $signed(bus.in_a) < $signed(bus.in_b)};
         OP_CMPLE: alu_y = {{(XLEN-1){1'b0}}, $signed(bus.in_a) <= $signed(bus.in_b)};
         OP_LDR:   alu_y = bus.in_b;
         default:  alu_y = '0;
      endcase
   end

   // Flush wins over everything: nothing is accepted while it is high.
   assign rdy    = !bus.flush && (state_q == S_IDLE || (state_q == S_HOLD && bus.out_ready));
   assign accept = bus.in_valid && rdy;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      st_d     = st_q;
      ir_d     = ir_q;
      y_d      = y_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_MUL: begin
            y_d      = mplier_q[0] ? y_q + mcand_q : y_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN - 1)) state_d = S_HOLD;
         end
         default: begin
            if (accept) begin
               pc_d = bus.in_pc;
               st_d = bus.in_st;
               ir_d = sel_ir;
               if (is_mul) begin
                  state_d  = S_MUL;
                  y_d      = '0;
                  mcand_d  = bus.in_a;
                  mplier_d = bus.in_b;
                  cnt_d    = '0;
               end else begin
                  state_d = S_HOLD;
                  y_d     = alu_y;
               end
            end else if (state_q == S_HOLD && bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
      endcase
      if (bus.flush) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         st_q     <= '0;
         y_q      <= '0;
         ir_q     <= `INST_NOP;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         st_q     <= st_d;
         y_q      <= y_d;
         ir_q     <= ir_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_valid = (state_q == S_HOLD);
   assign bus.busy      = (state_q == S_MUL);
   assign bus.out_pc    = pc_q;
   assign bus.out_y     = y_q;
   assign bus.out_st    = st_q;
   assign bus.out_ir    = ir_q;
   assign bus.dbg_state = state_q;
endmodule
